// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/ready/done handshake and operand/result bus for serial_subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    modport master (output start, a, b, bin, input ready, busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output ready, busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin through one full-subtractor cell; SERIAL_SUBTRACTOR_OVF_EN enables signed overflow
module serial_subtractor #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, work, work_nxt, diff_q;
    logic [CW-1:0]    cnt;
    logic             br, br_nxt, d, last, bout_q;
    // full-subtractor cell on the operand LSBs, plus the shifted-in result word
    always_comb begin
        d        = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        work_nxt = (work >> 1) | (WIDTH'(d) << (WIDTH - 1));
        last     = cnt == CW'(WIDTH - 1);
    end
    // next-state: start only honoured in IDLE, DONE always falls back to IDLE
    always_comb begin
        state_nxt = state;
        if (state == IDLE && bus.start) state_nxt = RUN;
        else if (state == RUN && last) state_nxt = DONE;
        else if (state == DONE) state_nxt = IDLE;
    end
    // datapath: load on accepted start, shift one bit per RUN cycle, capture result on last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                a_sh <= bus.a;
                b_sh <= bus.b;
                br   <= bus.bin;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                br   <= br_nxt;
                work <= work_nxt;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    diff_q <= work_nxt;
                    bout_q <= br_nxt;
                end
            end
        end
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb, b_msb, ovf_q;
    // overflow needs the operand signs as loaded and the final result bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (state == RUN && last) begin
            ovf_q <= (a_msb ^ b_msb) & (d ^ a_msb);
        end
    end
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
    assign bus.ready = state == IDLE;
    assign bus.busy  = state == RUN;
    assign bus.done  = state == DONE;
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing diff = a − b − bin one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart of the ripple full-adder datapath in the arithmetic library. It trades WIDTH+1 cycles of latency for a single-bit datapath, and sits behind a start/ready/done handshake for sequencer-driven ALU paths.

## Interface
- WIDTH, 8, operand and result width in bits, ≥ 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- a  input  WIDTH  minuend, sampled on accepted start
- b  input  WIDTH  subtrahend, sampled on accepted start
- bin  input  1  borrow-in, sampled on accepted start
- ready  output  1  high in IDLE only
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  result, held until next completion
- bout  output  1  final borrow-out, held with diff
- ovf  output  1  signed overflow, held with diff (see Configuration)

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN:
  - Taken when start=1.
  - Load a and b into shift registers.
  - Load the borrow flop with bin.
  - Clear the bit counter to 0.
- RUN, each cycle, using LSBs a0/b0 and borrow br:
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift a and b right.
  - Shift d into the MSB of the work register.
  - Increment the counter.
- RUN → DONE: after the cycle with counter = WIDTH−1.
  - Copy the work register to diff.
  - Copy br' to bout.
  - Compute ovf from the latched operand MSBs and the final d.
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- start outside IDLE is ignored and not queued; operand changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH:
  - bout=1 exactly when the unsigned a < b + bin.
  - ovf = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]).
- WIDTH=1: RUN lasts one cycle.
- Counter width is $clog2(WIDTH+1).

## Timing
- Reset values: ready=1, busy=0, done=0, diff=0, bout=0, ovf=0, state IDLE.
- Start sampled at edge E0.
  - busy=1 for cycles E0+1 … E0+WIDTH.
  - done=1 and diff/bout/ovf valid from edge E0+WIDTH+1.
  - ready returns at edge E0+WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- diff/bout/ovf change only at the RUN → DONE edge and are stable otherwise.
- rst_n low at any time, including mid-RUN:
  - Immediate return to reset values.
  - The partial result is discarded.
  - No done pulse.

## Configuration
- SERIAL_SUBTRACTOR_OVF_EN defined:
  - ovf computed as above.
  - MSB capture logic present.
- Not defined:
  - ovf is tied to 0.
  - No MSB capture logic is synthesized.
  - All other behaviour is identical.

## Test plan
- WIDTH=8: a=0x05, b=0x03, bin=0, start at E0 → done at E0+9, diff=0x02, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1 with macro, ovf=0 without.
- a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
  - Then start pulsed during RUN of the next op → ignored, exactly one done.
- rst_n pulsed low at E0+4 of an op → outputs 0, ready=1 immediately, no done.
  - Next op a=0xFF, b=0xFF → diff=0x00, bout=0.
- WIDTH=1: a=0, b=1, bin=1 → done at E0+2, diff=0, bout=1.
